// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_e;

  localparam logic [31:0] HALT_INST  = 32'hFFFF_FFFF;
  localparam logic [31:0] INST_BYTES = 32'd4;

  typedef struct packed {
    logic [31:0] code;
    logic [31:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_ctrl_if.sv
// Fetch-side bus: ROM read port, redirect input and decode-facing instruction stream.
interface fetch_ctrl_if import fetch_pkg::*; #(
  parameter int ADDR_W = 6
);

  logic              rom_en;
  logic [ADDR_W-1:0] rom_addr;
  logic [31:0]       rom_dout;
  logic              redirect;
  logic [31:0]       redirect_pc;
  // inst_* handshake: a word transfers on a rising edge where inst_valid && inst_ready;
  // inst_valid never depends on inst_ready, and code/pc hold while valid && !ready.
  logic              inst_valid;
  logic              inst_ready;
  logic [31:0]       inst_code;
  logic [31:0]       inst_pc;
  logic              halted;
  fetch_state_e      dbg_state;

  modport master (
    output rom_en, rom_addr, inst_valid, inst_code, inst_pc, halted, dbg_state,
    input  rom_dout, redirect, redirect_pc, inst_ready
  );

  modport slave (
    input  rom_en, rom_addr, inst_valid, inst_code, inst_pc, halted, dbg_state,
    output rom_dout, redirect, redirect_pc, inst_ready
  );

endinterface

// File: rtl/fetch_skid_buf.sv
// Two-entry ordered queue of fetched words; entry 0 is the output slot, entry 1 the skid slot.
module fetch_skid_buf import fetch_pkg::*; (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  fetch_entry_t push_entry,
  input  logic         fire,
  input  logic         flush,
  output logic         out_valid,
  output fetch_entry_t out_entry,
  output logic [1:0]   count
);

  fetch_entry_t [1:0] ent_q, ent_d;
  logic [1:0]         cnt_q, cnt_d;

  always_comb begin
    ent_d = ent_q;
    cnt_d = cnt_q;
    if (flush) begin
      ent_d = '0;
      cnt_d = 2'd0;
    end else begin
      if (fire && (cnt_q != 2'd0)) begin
        ent_d[0] = ent_q[1];
        ent_d[1] = '0;
        cnt_d    = cnt_q - 2'd1;
      end
      // Pushing after the pop lets a returning word land directly in a slot being vacated.
      if (push && (cnt_d != 2'd2)) begin
        ent_d[cnt_d[0]] = push_entry;
        cnt_d           = cnt_d + 2'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ent_q <= '0;
      cnt_q <= 2'd0;
    end else begin
      ent_q <= ent_d;
      cnt_q <= cnt_d;
    end
  end

  assign out_valid = (cnt_q != 2'd0);
  assign out_entry = ent_q[0];
  assign count     = cnt_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, issues 1-cycle-latency ROM reads, queues words for decode.
// Optional halt-on-HALT_INST behaviour is enabled with `define FETCH_HALT_EN.
module fetch_ctrl import fetch_pkg::*; #(
  parameter int          ADDR_W   = 6,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic          clk,
  input logic          rst,
  fetch_ctrl_if.master bus
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  inflight_pc_q, inflight_pc_d;
  logic         inflight_q, inflight_d;

  logic         fire, issue, take_redirect, halt_hit, push, flush, out_valid;
  logic [1:0]   buf_cnt, occ_left;
  fetch_entry_t out_entry, push_entry;

  assign fire          = out_valid && bus.inst_ready;
  assign take_redirect = bus.redirect && (state_q != HALT);
  // Occupancy after this cycle's transfer; a new read is allowed only if it still fits.
  assign occ_left      = buf_cnt + {1'b0, inflight_q} - {1'b0, fire};

`ifdef FETCH_HALT_EN
  assign halt_hit = (state_q == RUN) && fire && (out_entry.code == HALT_INST);
`else
  assign halt_hit = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = RUN;
      RUN:     if (halt_hit) state_d = HALT;
      HALT:    state_d = HALT;
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    issue = 1'b0;
    case (state_q)
      RUN:     issue = !bus.redirect && (occ_left < 2'd2);
      default: issue = 1'b0;
    endcase
  end

  // PC and in-flight tracking; the ROM answers the edge after issue, so a response
  // arriving alongside a redirect or halt is simply not pushed.
  always_comb begin
    pc_d          = pc_q;
    inflight_d    = issue;
    inflight_pc_d = inflight_pc_q;
    if (take_redirect) pc_d = {bus.redirect_pc[31:2], 2'b00};
    else if (issue)    pc_d = pc_q + INST_BYTES;
    if (issue)         inflight_pc_d = pc_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q          <= {RESET_PC[31:2], 2'b00};
      inflight_q    <= 1'b0;
      inflight_pc_q <= 32'd0;
    end else begin
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
    end
  end

  assign push       = inflight_q && (state_q == RUN) && !take_redirect && !halt_hit;
  assign flush      = take_redirect || halt_hit || (state_q == HALT);
  assign push_entry = '{code: bus.rom_dout, pc: inflight_pc_q};

  fetch_skid_buf u_skid (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_entry (push_entry),
    .fire       (fire),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_entry  (out_entry),
    .count      (buf_cnt)
  );

  assign bus.rom_en     = issue;
  assign bus.rom_addr   = pc_q[ADDR_W+1:2];
  assign bus.inst_valid = out_valid;
  assign bus.inst_code  = out_entry.code;
  assign bus.inst_pc    = out_entry.pc;
  assign bus.dbg_state  = state_q;
`ifdef FETCH_HALT_EN
  assign bus.halted     = (state_q == HALT);
`else
  assign bus.halted     = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: synchronous ROM model plus an expected-word scoreboard.
module tb_fetch_ctrl;
  import fetch_pkg::*;

  localparam int ADDR_W = 6;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fetch_ctrl_if #(.ADDR_W(ADDR_W)) bus();

  fetch_ctrl #(.ADDR_W(ADDR_W), .RESET_PC(32'h0000_0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [31:0] mem [64];
  logic [63:0] exp_q[$];
  int          n_vec    = 0;
  int          n_err    = 0;
  int          fire_cnt = 0;
  int          fc0;

  // ROM: one-cycle read latency
  always @(posedge clk) if (bus.rom_en) bus.rom_dout <= mem[bus.rom_addr];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard: every transfer must match the head of the expected stream
  always @(negedge clk) begin
    if (rst && bus.inst_valid && bus.inst_ready) begin
      fire_cnt++;
      if (exp_q.size() == 0) check("extra_word", 64'd1, 64'd0);
      else                   check("word", {bus.inst_code, bus.inst_pc}, exp_q.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic to_neg();
    @(negedge clk);
  endtask

  task automatic push_exp(input logic [31:0] start, input int n);
    logic [31:0] p;
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
      p = start + 32'(4 * i);
      exp_q.push_back({mem[p[7:2]], p});
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_rom_en"}, 64'(bus.rom_en), 64'd0);
    check({tag, "_valid"},  64'(bus.inst_valid), 64'd0);
    check({tag, "_code"},   64'(bus.inst_code), 64'd0);
    check({tag, "_pc"},     64'(bus.inst_pc), 64'd0);
    check({tag, "_halted"}, 64'(bus.halted), 64'd0);
  endtask

  // Entered just after an edge with rst low; leaves just after E3
  task automatic release_reset(input int n_exp);
    push_exp(32'h0, n_exp);
    rst            = 1'b1;
    bus.inst_ready = 1'b1;
    tick(); to_neg();
    check("e0_rom_en", 64'(bus.rom_en), 64'd1);
    check("e0_rom_addr", 64'(bus.rom_addr), 64'd0);
    check("e0_valid", 64'(bus.inst_valid), 64'd0);
    check("e0_state", 64'(bus.dbg_state), 64'(RUN));
    tick(); to_neg();
    check("e1_rom_en", 64'(bus.rom_en), 64'd1);
    check("e1_rom_addr", 64'(bus.rom_addr), 64'd1);
    check("e1_valid", 64'(bus.inst_valid), 64'd0);
    tick(); to_neg();
    check("e2_valid", 64'(bus.inst_valid), 64'd1);
    check("e2_pc", 64'(bus.inst_pc), 64'd0);
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'(i);
    bus.inst_ready  = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 32'd0;

    // Reset state
    repeat (3) tick();
    to_neg();
    check_zero_outputs("rst");
    check("rst_state", 64'(bus.dbg_state), 64'(IDLE));
    tick();

    // Startup and sustained throughput
    release_reset(200);
    fc0 = fire_cnt;
    repeat (10) tick();
    check("throughput", 64'(fire_cnt - fc0), 64'd10);

    // Stall: fetch stops at occupancy 2 and the output holds
    bus.inst_ready = 1'b0;
    fc0 = fire_cnt;
    for (int i = 0; i < 5; i++) begin
      to_neg();
      check("stall_rom_en", 64'(bus.rom_en), 64'd0);
      check("stall_valid", 64'(bus.inst_valid), 64'd1);
      check("stall_hold", {bus.inst_code, bus.inst_pc}, exp_q[0]);
      tick();
    end
    check("stall_no_fire", 64'(fire_cnt - fc0), 64'd0);
    bus.inst_ready = 1'b1;
    fc0 = fire_cnt;
    to_neg();
    check("resume_rom_en", 64'(bus.rom_en), 64'd1);
    tick();
    repeat (7) tick();
    check("resume_rate", 64'(fire_cnt - fc0), 64'd8);

    // Redirect with a queued word and a read in flight
    bus.inst_ready  = 1'b0;
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h23;
    push_exp(32'h20, 200);
    to_neg();
    check("redir_no_issue", 64'(bus.rom_en), 64'd0);
    tick();
    bus.redirect   = 1'b0;
    bus.inst_ready = 1'b1;
    to_neg();
    check("redir_valid0", 64'(bus.inst_valid), 64'd0);
    check("redir_rom_en", 64'(bus.rom_en), 64'd1);
    check("redir_rom_addr", 64'(bus.rom_addr), 64'd8);
    tick(); to_neg();
    check("redir_valid1", 64'(bus.inst_valid), 64'd0);
    tick(); to_neg();
    check("redir_valid2", 64'(bus.inst_valid), 64'd1);
    check("redir_pc", 64'(bus.inst_pc), 64'h20);
    tick();
    repeat (5) tick();

    // Back-to-back redirects: the second target wins
    bus.inst_ready  = 1'b0;
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h40;
    tick();
    bus.redirect_pc = 32'h80;
    push_exp(32'h80, 200);
    tick();
    bus.redirect   = 1'b0;
    bus.inst_ready = 1'b1;
    repeat (2) tick();
    to_neg();
    check("b2b_pc", 64'(bus.inst_pc), 64'h80);
    tick();
    repeat (4) tick();

    // ROM address wrap
    bus.inst_ready  = 1'b0;
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'hF8;
    push_exp(32'hF8, 200);
    tick();
    bus.redirect   = 1'b0;
    bus.inst_ready = 1'b1;
    to_neg();
    check("wrap_addr62", 64'(bus.rom_addr), 64'd62);
    tick(); to_neg();
    check("wrap_addr63", 64'(bus.rom_addr), 64'd63);
    tick(); to_neg();
    check("wrap_addr0", 64'(bus.rom_addr), 64'd0);
    check("wrap_pc", 64'(bus.inst_pc), 64'hF8);
    tick();
    repeat (6) tick();

    // Reset with occupancy 2, then restart
    bus.inst_ready = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick(); to_neg();
    check_zero_outputs("midrst");
    tick();
    release_reset(200);
    repeat (6) tick();

    // Word 3 is the halt encoding
    rst            = 1'b0;
    bus.inst_ready = 1'b0;
    mem[3]         = HALT_INST;
    repeat (2) tick();
`ifdef FETCH_HALT_EN
    release_reset(4);
    repeat (8) tick();
    check("halt_all_words", 64'(exp_q.size()), 64'd0);
    to_neg();
    check("halt_flag", 64'(bus.halted), 64'd1);
    check("halt_valid", 64'(bus.inst_valid), 64'd0);
    check("halt_rom_en", 64'(bus.rom_en), 64'd0);
    tick();
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h20;
    tick();
    bus.redirect = 1'b0;
    repeat (4) tick();
    to_neg();
    check("halt_redir_flag", 64'(bus.halted), 64'd1);
    check("halt_redir_valid", 64'(bus.inst_valid), 64'd0);
    check("halt_state", 64'(bus.dbg_state), 64'(HALT));
`else
    release_reset(200);
    repeat (8) tick();
    check("nohalt_words", 64'(exp_q.size()), 64'd191);
    to_neg();
    check("nohalt_flag", 64'(bus.halted), 64'd0);
    check("nohalt_valid", 64'(bus.inst_valid), 64'd1);
`endif
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
